// File: rtl/pixel_point_op.sv
// Dual-pixel RGB888 point-operation stage: 2-cycle pipeline with frame-constant
// operation select, hsync/vsync realignment and frame/line position tracking.
module pixel_point_op #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] r0_in,
    input  logic [7:0] g0_in,
    input  logic [7:0] b0_in,
    input  logic [7:0] r1_in,
    input  logic [7:0] g1_in,
    input  logic [7:0] b1_in,
    input  logic [2:0] mode,
    input  logic [7:0] value,
    input  logic [7:0] threshold,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] r0_out,
    output logic [7:0] g0_out,
    output logic [7:0] b0_out,
    output logic [7:0] r1_out,
    output logic [7:0] g1_out,
    output logic [7:0] b1_out,
    output logic       frame_done,
    output logic       line_err
);

    localparam int PAIRS  = WIDTH / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HEIGHT - 1);

    localparam logic [2:0] MODE_INVERT   = 3'd1;
    localparam logic [2:0] MODE_BRIGHTEN = 3'd2;
    localparam logic [2:0] MODE_DARKEN   = 3'd3;
    localparam logic [2:0] MODE_GRAY     = 3'd4;
    localparam logic [2:0] MODE_BINARY   = 3'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Luma approximation (r + 2g + b) / 4; the 10-bit sum cannot overflow.
    function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

    function automatic logic [7:0] point_op(input logic [2:0] op, input logic [7:0] x,
                                            input logic [7:0] gray, input logic [7:0] offset,
                                            input logic [7:0] level);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, x} + {1'b0, offset};
        case (op)
            MODE_INVERT:   res = 8'd255 - x;
            MODE_BRIGHTEN: res = sum[8] ? 8'hFF : sum[7:0];
            MODE_DARKEN:   res = (x > offset) ? (x - offset) : 8'h00;
            MODE_GRAY:     res = gray;
            MODE_BINARY:   res = (gray >= level) ? 8'hFF : 8'h00;
            default:       res = x;  // bypass, including the unused codes 6 and 7
        endcase
        return res;
    endfunction

    logic       s1_valid;
    logic       s1_vsync;
    rgb_t       s1_px0;
    rgb_t       s1_px1;
    logic [7:0] s1_gray0;
    logic [7:0] s1_gray1;

    logic [2:0] cfg_mode;
    logic [7:0] cfg_value;
    logic [7:0] cfg_threshold;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PAIR_W-1:0] pair_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              cfg_latch;
    logic              frame_end;

    rgb_t nxt0;
    rgb_t nxt1;
    rgb_t out0;
    rgb_t out1;

    assign cfg_latch = (state == ST_IDLE) && hsync_in;
    assign frame_end = (state == ST_ACTIVE) && hsync_out &&
                       (pair_cnt == LAST_PAIR) && (line_cnt == LAST_LINE);

    // Stage 1: capture the pair and precompute each pixel's gray level.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: datapath registers are reset as well, so outputs read 0 the moment rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vsync <= 1'b0;
            s1_px0   <= '0;
            s1_px1   <= '0;
            s1_gray0 <= '0;
            s1_gray1 <= '0;
        end else begin
            s1_valid <= hsync_in;
            s1_vsync <= vsync_in;
            s1_px0   <= {r0_in, g0_in, b0_in};
            s1_px1   <= {r1_in, g1_in, b1_in};
            s1_gray0 <= gray_of(r0_in, g0_in, b0_in);
            s1_gray1 <= gray_of(r1_in, g1_in, b1_in);
        end
    end

    // Configuration is taken from the inputs on the frame's first valid pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode      <= '0;
            cfg_value     <= '0;
            cfg_threshold <= '0;
        end else if (cfg_latch) begin
            cfg_mode      <= mode;
            cfg_value     <= value;
            cfg_threshold <= threshold;
        end
    end

    // Stage 2 datapath; invalid slots are forced to zero.
    // NOTE: defaults first so every path assigns the outputs; otherwise latches are inferred.
    always_comb begin
        nxt0 = '0;
        nxt1 = '0;
        if (s1_valid) begin
            nxt0.r = point_op(cfg_mode, s1_px0.r, s1_gray0, cfg_value, cfg_threshold);
            nxt0.g = point_op(cfg_mode, s1_px0.g, s1_gray0, cfg_value, cfg_threshold);
            nxt0.b = point_op(cfg_mode, s1_px0.b, s1_gray0, cfg_value, cfg_threshold);
            nxt1.r = point_op(cfg_mode, s1_px1.r, s1_gray1, cfg_value, cfg_threshold);
            nxt1.g = point_op(cfg_mode, s1_px1.g, s1_gray1, cfg_value, cfg_threshold);
            nxt1.b = point_op(cfg_mode, s1_px1.b, s1_gray1, cfg_value, cfg_threshold);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            out0      <= '0;
            out1      <= '0;
        end else begin
            hsync_out <= s1_valid;
            vsync_out <= s1_vsync;
            out0      <= nxt0;
            out1      <= nxt1;
        end
    end

    assign r0_out = out0.r;
    assign g0_out = out0.g;
    assign b0_out = out0.b;
    assign r1_out = out1.r;
    assign g1_out = out1.g;
    assign b1_out = out1.b;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cfg_latch) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (frame_end) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Position counters follow the output side; a line that ends early is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
            line_cnt <= '0;
        end else if (state == ST_DONE) begin
            pair_cnt <= '0;
            line_cnt <= '0;
        end else if (state == ST_ACTIVE) begin
            if (hsync_out) begin
                if (pair_cnt == LAST_PAIR) begin
                    pair_cnt <= '0;
                    line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
                end else begin
                    pair_cnt <= pair_cnt + 1'b1;
                end
            end else if (pair_cnt != '0) begin
                pair_cnt <= '0;
            end
        end
    end

    // pair_cnt is only non-zero right after an hsync_out high cycle, so this detects the fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err <= 1'b0;
        end else if (cfg_latch) begin
            line_err <= 1'b0;
        end else if ((state == ST_ACTIVE) && !hsync_out && (pair_cnt != '0)) begin
            line_err <= 1'b1;
        end
    end

    assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_pixel_point_op.sv
// Directed bench for pixel_point_op on a 4x2 frame (2 pairs per line, 2 lines).
module tb_pixel_point_op;

    localparam int W           = 4;
    localparam int H           = 2;
    localparam int FRAME_PAIRS = 4;

    logic       clk;
    logic       rst_n;
    logic       hsync_in, vsync_in;
    logic [7:0] r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
    logic [2:0] mode;
    logic [7:0] value, threshold;
    logic       hsync_out, vsync_out;
    logic [7:0] r0_out, g0_out, b0_out, r1_out, g1_out, b1_out;
    logic       frame_done, line_err;

    pixel_point_op #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
        .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
        .mode(mode), .value(value), .threshold(threshold),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .r0_out(r0_out), .g0_out(g0_out), .b0_out(b0_out),
        .r1_out(r1_out), .g1_out(g1_out), .b1_out(b1_out),
        .frame_done(frame_done), .line_err(line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim_px   [FRAME_PAIRS][6];
    logic [2:0]  stim_mode [FRAME_PAIRS];
    logic [7:0]  stim_value;
    logic [7:0]  stim_thr;
    logic [47:0] obs_px    [FRAME_PAIRS];
    int          obs_cyc   [FRAME_PAIRS];
    int          obs_cnt, fd_count, fd_cycle, vs_cycle, gate_bad, err_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = '0;
    endtask

    function automatic logic [47:0] outs();
        return {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out};
    endfunction

    task automatic set_pair(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] e, input logic [7:0] f);
        stim_px[k][0] = a; stim_px[k][1] = b; stim_px[k][2] = c;
        stim_px[k][3] = d; stim_px[k][4] = e; stim_px[k][5] = f;
    endtask

    task automatic set_modes(input logic [2:0] m0, input logic [2:0] m1,
                             input logic [2:0] m2, input logic [2:0] m3);
        stim_mode[0] = m0; stim_mode[1] = m1; stim_mode[2] = m2; stim_mode[3] = m3;
    endtask

    // Drives one 4-pair frame starting in cycle 0 and records what appears on the outputs.
    task automatic stream_frame(input int n_cyc);
        obs_cnt = 0; fd_count = 0; fd_cycle = -1; vs_cycle = -1; gate_bad = 0; err_seen = 0;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            if (cyc < FRAME_PAIRS) begin
                hsync_in = 1'b1;
                vsync_in = (cyc == 0);
                r0_in = stim_px[cyc][0]; g0_in = stim_px[cyc][1]; b0_in = stim_px[cyc][2];
                r1_in = stim_px[cyc][3]; g1_in = stim_px[cyc][4]; b1_in = stim_px[cyc][5];
                mode  = stim_mode[cyc];
            end else begin
                drive_idle();
                mode = stim_mode[FRAME_PAIRS-1];
            end
            value     = stim_value;
            threshold = stim_thr;
            tick();
            if (hsync_out) begin
                if (obs_cnt < FRAME_PAIRS) begin
                    obs_px[obs_cnt]  = outs();
                    obs_cyc[obs_cnt] = cyc + 1;
                end
                obs_cnt++;
            end else if (outs() != 48'd0) begin
                gate_bad++;
            end
            if (frame_done) begin
                fd_count++;
                fd_cycle = cyc + 1;
            end
            if (vsync_out) vs_cycle = cyc + 1;
            if (line_err) err_seen++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        hsync_in = 1'b1; vsync_in = 1'b1; r0_in = 8'hAA; g1_in = 8'h55;
        mode = 3'd5; value = 8'd9; threshold = 8'd3;
        repeat (3) tick();
        total++;
        if ({hsync_out, vsync_out, outs(), frame_done, line_err} !== 52'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {hsync_out, vsync_out, outs(), frame_done, line_err});
        end
        drive_idle();
        mode = 3'd0; value = 8'd0; threshold = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        logic [47:0] exp_px;
        for (int k = 0; k < FRAME_PAIRS; k++)
            set_pair(k, 8'(10 + k), 8'd20, 8'd30, 8'd40, 8'd50, 8'(60 + k));
        set_modes(3'd0, 3'd0, 3'd0, 3'd0);
        stim_value = 8'd0; stim_thr = 8'd0;
        stream_frame(10);
        total++;
        if (obs_cnt !== FRAME_PAIRS) begin
            bad++; $display("FAIL bypass_count: got %0d expected %0d", obs_cnt, FRAME_PAIRS);
        end
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            exp_px = {8'(10 + k), 8'd20, 8'd30, 8'd40, 8'd50, 8'(60 + k)};
            total++;
            if (obs_px[k] !== exp_px) begin
                bad++; $display("FAIL bypass_pair%0d: got %h expected %h", k, obs_px[k], exp_px);
            end
            total++;
            if (obs_cyc[k] !== k + 2) begin
                bad++; $display("FAIL latency_pair%0d: got cycle %0d expected %0d", k, obs_cyc[k], k + 2);
            end
        end
        total++;
        if (fd_count !== 1 || fd_cycle !== 6) begin
            bad++; $display("FAIL frame_done: got count %0d cycle %0d expected 1 at 6", fd_count, fd_cycle);
        end
        total++;
        if (vs_cycle !== 2) begin
            bad++; $display("FAIL vsync_delay: got cycle %0d expected 2", vs_cycle);
        end
        total++;
        if (gate_bad !== 0) begin
            bad++; $display("FAIL gating: got %0d nonzero idle cycles expected 0", gate_bad);
        end
        total++;
        if (err_seen !== 0) begin
            bad++; $display("FAIL bypass_line_err: got %0d cycles high expected 0", err_seen);
        end
    endtask

    task automatic test_invert();
        for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd0, 8'd255, 8'd100, 8'd1, 8'd128, 8'd254);
        set_modes(3'd1, 3'd7, 3'd7, 3'd7);
        stim_value = 8'd0; stim_thr = 8'd0;
        stream_frame(10);
        total++;
        if (obs_cnt !== FRAME_PAIRS) begin
            bad++; $display("FAIL invert_count: got %0d expected %0d", obs_cnt, FRAME_PAIRS);
        end
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== {8'd255, 8'd0, 8'd155, 8'd254, 8'd127, 8'd1}) begin
                bad++; $display("FAIL invert_pair%0d: got %h expected ff009bfe7f01", k, obs_px[k]);
            end
        end
    endtask

    task automatic test_brighten_darken();
        for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd220, 8'd100, 8'd205, 8'd0, 8'd255, 8'd206);
        set_modes(3'd2, 3'd2, 3'd2, 3'd2);
        stim_value = 8'd50; stim_thr = 8'd0;
        stream_frame(10);
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== {8'd255, 8'd150, 8'd255, 8'd50, 8'd255, 8'd255}) begin
                bad++; $display("FAIL brighten_pair%0d: got %h expected ff96ff32ffff", k, obs_px[k]);
            end
        end
        for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd30, 8'd50, 8'd51, 8'd255, 8'd0, 8'd100);
        set_modes(3'd3, 3'd3, 3'd3, 3'd3);
        stream_frame(10);
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== {8'd0, 8'd0, 8'd1, 8'd205, 8'd0, 8'd50}) begin
                bad++; $display("FAIL darken_pair%0d: got %h expected 000001cd0032", k, obs_px[k]);
            end
        end
    endtask

    task automatic test_gray_threshold();
        logic [47:0] exp_px [FRAME_PAIRS];
        // gray(100,150,200)=150, gray(255,255,255)=255, gray(1,2,3)=2, gray(200,10,90)=77
        for (int k = 0; k < FRAME_PAIRS; k += 2) begin
            set_pair(k,     8'd100, 8'd150, 8'd200, 8'd255, 8'd255, 8'd255);
            set_pair(k + 1, 8'd1, 8'd2, 8'd3, 8'd200, 8'd10, 8'd90);
            exp_px[k]     = {8'd150, 8'd150, 8'd150, 8'd255, 8'd255, 8'd255};
            exp_px[k + 1] = {8'd2, 8'd2, 8'd2, 8'd77, 8'd77, 8'd77};
        end
        set_modes(3'd4, 3'd4, 3'd4, 3'd4);
        stim_value = 8'd50; stim_thr = 8'd0;
        stream_frame(10);
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== exp_px[k]) begin
                bad++; $display("FAIL gray_pair%0d: got %h expected %h", k, obs_px[k], exp_px[k]);
            end
        end
        // gray 150 and 128 reach the level, gray 0 and 127 do not
        for (int k = 0; k < FRAME_PAIRS; k += 2) begin
            set_pair(k,     8'd100, 8'd150, 8'd200, 8'd0, 8'd0, 8'd0);
            set_pair(k + 1, 8'd128, 8'd128, 8'd128, 8'd127, 8'd128, 8'd128);
            exp_px[k]     = {24'hFFFFFF, 24'h000000};
            exp_px[k + 1] = {24'hFFFFFF, 24'h000000};
        end
        set_modes(3'd5, 3'd5, 3'd5, 3'd5);
        stim_thr = 8'd128;
        stream_frame(10);
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== exp_px[k]) begin
                bad++; $display("FAIL threshold_pair%0d: got %h expected %h", k, obs_px[k], exp_px[k]);
            end
        end
    endtask

    task automatic test_reserved_modes();
        for (int m = 6; m < 8; m++) begin
            for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'(6 + k));
            set_modes(3'(m), 3'(m), 3'(m), 3'(m));
            stim_value = 8'd77; stim_thr = 8'd200;
            stream_frame(10);
            total++;
            if (obs_px[3] !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9}) begin
                bad++; $display("FAIL reserved_mode%0d: got %h expected 010203040509", m, obs_px[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd0, 8'd255, 8'd100, 8'd1, 8'd128, 8'd254);
        set_modes(3'd1, 3'd0, 3'd0, 3'd7);
        stim_value = 8'd0; stim_thr = 8'd0;
        stream_frame(7);  // next frame begins the cycle after frame_done
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== {8'd255, 8'd0, 8'd155, 8'd254, 8'd127, 8'd1}) begin
                bad++; $display("FAIL held_mode_pair%0d: got %h expected ff009bfe7f01", k, obs_px[k]);
            end
        end
        total++;
        if (fd_count !== 1 || fd_cycle !== 6) begin
            bad++; $display("FAIL b2b_first_done: got count %0d cycle %0d expected 1 at 6", fd_count, fd_cycle);
        end
        set_modes(3'd0, 3'd1, 3'd1, 3'd1);
        stream_frame(10);
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            total++;
            if (obs_px[k] !== {8'd0, 8'd255, 8'd100, 8'd1, 8'd128, 8'd254}) begin
                bad++; $display("FAIL b2b_bypass_pair%0d: got %h expected 00ff640180fe", k, obs_px[k]);
            end
        end
        total++;
        if (fd_count !== 1 || fd_cycle !== 6 || obs_cyc[0] !== 2) begin
            bad++; $display("FAIL b2b_second_frame: got done count %0d cycle %0d first out %0d expected 1, 6, 2",
                            fd_count, fd_cycle, obs_cyc[0]);
        end
    endtask

    task automatic test_line_err_and_reset();
        int done_seen;
        mode = 3'd0; value = 8'd0; threshold = 8'd0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        tick();
        drive_idle();
        tick();
        total++;
        if (!hsync_out || outs() !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6} || line_err) begin
            bad++; $display("FAIL short_line_pair: got hs %b data %h err %b expected 1 010203040506 0",
                            hsync_out, outs(), line_err);
        end
        tick();
        tick();
        total++;
        if (line_err !== 1'b1) begin
            bad++; $display("FAIL line_err_set: got %b expected 1", line_err);
        end
        repeat (3) tick();
        total++;
        if (line_err !== 1'b1 || hsync_out !== 1'b0 || outs() !== 48'd0) begin
            bad++; $display("FAIL line_err_sticky: got err %b hs %b data %h expected 1 0 0",
                            line_err, hsync_out, outs());
        end
        // A full line afterwards keeps the flag and does not complete the frame.
        done_seen = 0;
        hsync_in = 1'b1;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        for (int c = 0; c < 6; c++) begin
            if (c == 2) drive_idle();
            tick();
            if (frame_done) done_seen++;
        end
        total++;
        if (line_err !== 1'b1 || done_seen !== 0) begin
            bad++; $display("FAIL line_err_full_line: got err %b done %0d expected 1 0", line_err, done_seen);
        end
        // Start the next line, then reset while its pair is on the outputs.
        hsync_in = 1'b1;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = {8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        tick();
        drive_idle();
        tick();
        total++;
        if (hsync_out !== 1'b1) begin
            bad++; $display("FAIL pre_reset_hsync: got %b expected 1", hsync_out);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({hsync_out, vsync_out, outs(), frame_done, line_err} !== 52'd0) begin
            bad++; $display("FAIL midframe_reset: got %h expected 0",
                            {hsync_out, vsync_out, outs(), frame_done, line_err});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // A clean frame must finish after exactly four pairs.
        for (int k = 0; k < FRAME_PAIRS; k++) set_pair(k, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'(66 + k));
        set_modes(3'd0, 3'd0, 3'd0, 3'd0);
        stim_value = 8'd0; stim_thr = 8'd0;
        stream_frame(10);
        total++;
        if (fd_count !== 1 || fd_cycle !== 6 || err_seen !== 0) begin
            bad++; $display("FAIL post_reset_frame: got done %0d at %0d err %0d expected 1 at 6 err 0",
                            fd_count, fd_cycle, err_seen);
        end
        total++;
        if (obs_px[3] !== {8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd69}) begin
            bad++; $display("FAIL post_reset_data: got %h expected 0b16212c3745", obs_px[3]);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_invert();
        test_brighten_darken();
        test_gray_threshold();
        test_reserved_modes();
        test_back_to_back();
        test_line_err_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
